// File: rtl/ibex_obi_mux.sv
// N-to-1 OBI multiplexer: round-robin arbitration with request locking, plus an
// in-order tag FIFO that routes each downstream response back to its originating port.
module ibex_obi_mux #(
   parameter int unsigned NumPorts       = 2,
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [NumPorts-1:0]             req_i,
   output logic [NumPorts-1:0]             gnt_o,
   input  logic [NumPorts-1:0]             we_i,
   input  logic [NumPorts*DataWidth/8-1:0] be_i,
   input  logic [NumPorts*AddrWidth-1:0]   addr_i,
   input  logic [NumPorts*DataWidth-1:0]   wdata_i,
   output logic [NumPorts-1:0]             rvalid_o,
   output logic [DataWidth-1:0]            rdata_o,
   output logic                            err_o,
   output logic                            mem_req_o,
   input  logic                            mem_gnt_i,
   output logic                            mem_we_o,
   output logic [DataWidth/8-1:0]          mem_be_o,
   output logic [AddrWidth-1:0]            mem_addr_o,
   output logic [DataWidth-1:0]            mem_wdata_o,
   input  logic                            mem_rvalid_i,
   input  logic [DataWidth-1:0]            mem_rdata_i,
   input  logic                            mem_err_i,
   output logic                            proto_err_o
);

   localparam int unsigned BeWidth = DataWidth / 8;
   localparam int unsigned IdxW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
   localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);

   logic                ready;
   logic                lock;
   logic [IdxW-1:0]     lock_idx;
   logic [IdxW-1:0]     rr_ptr;
   logic [CntW-1:0]     count;
   logic [PtrW-1:0]     wr_ptr;
   logic [PtrW-1:0]     rd_ptr;
   logic [IdxW-1:0]     tag_mem [MaxOutstanding];

   logic [IdxW-1:0]     rr_sel;
   logic [IdxW-1:0]     sel;
   logic [IdxW-1:0]     cand;
   logic [IdxW-1:0]     head;
   logic                found;
   logic                full;
   logic                accept;
   logic                pop;
   int unsigned         pos;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Round-robin search: first requesting port at or after rr_ptr, wrapping around.
   always_comb begin
      rr_sel = rr_ptr;
      found  = 1'b0;
      pos    = 0;
      cand   = '0;
      for (int i = 0; i < NumPorts; i++) begin
         pos = 32'(rr_ptr) + unsigned'(i);
         if (pos >= NumPorts) pos = pos - NumPorts;
         cand = IdxW'(pos);
         if (!found && req_i[cand]) begin
            found  = 1'b1;
            rr_sel = cand;
         end
      end
   end

   assign sel       = lock ? lock_idx : rr_sel;
   assign full      = (count == CntW'(MaxOutstanding));
   assign mem_req_o = ready & ~full & (lock | (|req_i));
   assign accept    = mem_req_o & mem_gnt_i;
   assign pop       = ready & mem_rvalid_i & (count != '0);
   assign head      = tag_mem[rd_ptr];
   assign rdata_o   = mem_rdata_i;
   assign err_o     = mem_err_i;

   always_comb begin
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      for (int p = 0; p < NumPorts; p++) begin
         if (sel == IdxW'(p)) begin
            mem_we_o    = we_i[p];
            mem_be_o    = be_i[p*BeWidth +: BeWidth];
            mem_addr_o  = addr_i[p*AddrWidth +: AddrWidth];
            mem_wdata_o = wdata_i[p*DataWidth +: DataWidth];
         end
      end
   end

   always_comb begin
      gnt_o         = '0;
      gnt_o[sel]    = accept;
      rvalid_o      = '0;
      rvalid_o[head] = pop;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ready       <= 1'b0;
         lock        <= 1'b0;
         lock_idx    <= '0;
         rr_ptr      <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         proto_err_o <= 1'b0;
         for (int i = 0; i < MaxOutstanding; i++) tag_mem[i] <= '0;
      end else begin
         ready <= 1'b1;
         // A stalled request pins the payload to its port until the bus grants it.
         if (accept) begin
            lock   <= 1'b0;
            rr_ptr <= (sel == IdxW'(NumPorts - 1)) ? '0 : sel + IdxW'(1);
         end else if (mem_req_o) begin
            lock     <= 1'b1;
            lock_idx <= sel;
         end
         if (accept) begin
            tag_mem[wr_ptr] <= sel;
            wr_ptr          <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({accept, pop})
            2'b10:   count <= count + CntW'(1);
            2'b01:   count <= count - CntW'(1);
            default: count <= count;
         endcase
         if (mem_rvalid_i && count == '0) proto_err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ibex_obi_mux.sv
// Bench for ibex_obi_mux: directed scenarios plus a randomized run against a
// port-level reference model (pending requests, rotating priority, response order queue).
module tb_ibex_obi_mux;

   localparam int NP = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int MO = 2;

   logic              clk = 1'b0;
   logic              rstn;
   logic [NP-1:0]     req_i;
   logic [NP-1:0]     gnt_o;
   logic [NP-1:0]     we_i;
   logic [NP*BW-1:0]  be_i;
   logic [NP*AW-1:0]  addr_i;
   logic [NP*DW-1:0]  wdata_i;
   logic [NP-1:0]     rvalid_o;
   logic [DW-1:0]     rdata_o;
   logic              err_o;
   logic              mem_req_o;
   logic              mem_gnt_i;
   logic              mem_we_o;
   logic [BW-1:0]     mem_be_o;
   logic [AW-1:0]     mem_addr_o;
   logic [DW-1:0]     mem_wdata_o;
   logic              mem_rvalid_i;
   logic [DW-1:0]     mem_rdata_i;
   logic              mem_err_i;
   logic              proto_err_o;

   int tests_run    = 0;
   int tests_failed = 0;

   // reference model state
   logic [NP-1:0]  pend;
   logic [AW-1:0]  p_addr  [NP];
   logic           p_we    [NP];
   logic [BW-1:0]  p_be    [NP];
   logic [DW-1:0]  p_wdata [NP];
   int             rr;
   int             locked;
   logic [7:0]     exp_q[$];

   ibex_obi_mux #(
      .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
   ) dut (
      .clk(clk), .rstn(rstn),
      .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .be_i(be_i),
      .addr_i(addr_i), .wdata_i(wdata_i),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
      .proto_err_o(proto_err_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // drivers
   task automatic idle();
      req_i        = '0;
      we_i         = '0;
      be_i         = '0;
      addr_i       = '0;
      wdata_i      = '0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      mem_err_i    = 1'b0;
   endtask

   task automatic set_port(input int p, input logic r, input logic [AW-1:0] a);
      req_i[p]            = r;
      we_i[p]             = 1'b0;
      be_i[p*BW +: BW]    = '1;
      addr_i[p*AW +: AW]  = a;
      wdata_i[p*DW +: DW] = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      idle();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      idle();
      rstn = 1'b0;
      set_port(0, 1'b1, 32'h0000_1000);
      set_port(1, 1'b1, 32'h0000_2000);
      mem_gnt_i    = 1'b1;
      mem_rvalid_i = 1'b1;
      #1;
      tests_run++;
      if (mem_req_o !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %0b expected 0", mem_req_o); end
      tests_run++;
      if (gnt_o !== 2'b00) begin tests_failed++; $display("FAIL reset_gnt: got %b expected 00", gnt_o); end
      tests_run++;
      if (rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL reset_rvalid: got %b expected 00", rvalid_o); end
      tests_run++;
      if (proto_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_proto_err: got %0b expected 0", proto_err_o); end
      @(negedge clk);
      rstn         = 1'b1;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      #1;
      tests_run++;
      if (mem_req_o !== 1'b0) begin tests_failed++; $display("FAIL not_ready_req: got %0b expected 0", mem_req_o); end
      @(negedge clk);
      #1;
      tests_run++;
      if (mem_req_o !== 1'b1) begin tests_failed++; $display("FAIL ready_req: got %0b expected 1", mem_req_o); end
      tests_run++;
      if (mem_addr_o !== 32'h0000_1000) begin tests_failed++; $display("FAIL ready_addr: got %h expected 00001000", mem_addr_o); end
      apply_reset();
   endtask

   task automatic test_single_read();
      apply_reset();
      set_port(0, 1'b1, 32'h0001_0000);
      mem_gnt_i = 1'b1;
      #1;
      tests_run++;
      if (gnt_o !== 2'b01) begin tests_failed++; $display("FAIL t1_gnt: got %b expected 01", gnt_o); end
      tests_run++;
      if (mem_addr_o !== 32'h0001_0000) begin tests_failed++; $display("FAIL t1_addr: got %h expected 00010000", mem_addr_o); end
      @(negedge clk);
      idle();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEAD_BEEF;
      #1;
      tests_run++;
      if (rvalid_o !== 2'b01) begin tests_failed++; $display("FAIL t1_rvalid: got %b expected 01", rvalid_o); end
      tests_run++;
      if (rdata_o !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL t1_rdata: got %h expected deadbeef", rdata_o); end
      @(negedge clk);
      idle();
   endtask

   task automatic test_contention();
      logic [NP-1:0] exp_g, exp_rv;
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         set_port(0, 1'b1, 32'h100 + 32'(k));
         set_port(1, 1'b1, 32'h200 + 32'(k));
         mem_gnt_i    = 1'b1;
         mem_rvalid_i = (k > 0);
         exp_g  = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_rv = (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
         #1;
         tests_run++;
         if (gnt_o !== exp_g) begin tests_failed++; $display("FAIL t2_gnt[%0d]: got %b expected %b", k, gnt_o, exp_g); end
         tests_run++;
         if (rvalid_o !== exp_rv) begin tests_failed++; $display("FAIL t2_rvalid[%0d]: got %b expected %b", k, rvalid_o, exp_rv); end
         @(negedge clk);
      end
      idle();
      mem_rvalid_i = 1'b1;
      #1;
      tests_run++;
      if (rvalid_o !== 2'b10) begin tests_failed++; $display("FAIL t2_drain: got %b expected 10", rvalid_o); end
      @(negedge clk);
      idle();
   endtask

   task automatic test_lock();
      apply_reset();
      set_port(0, 1'b1, 32'hA000);
      mem_gnt_i = 1'b1;
      @(negedge clk);
      idle();
      mem_rvalid_i = 1'b1;
      #1;
      tests_run++;
      if (rvalid_o !== 2'b01) begin tests_failed++; $display("FAIL t3_first_rsp: got %b expected 01", rvalid_o); end
      // rr now favours port 1; port 0 stalls and must keep the bus when port 1 arrives
      @(negedge clk);
      idle();
      set_port(0, 1'b1, 32'hA004);
      #1;
      tests_run++;
      if (mem_addr_o !== 32'hA004 || gnt_o !== 2'b00) begin tests_failed++; $display("FAIL t3_stall: got addr %h gnt %b expected a004 00", mem_addr_o, gnt_o); end
      @(negedge clk);
      set_port(1, 1'b1, 32'hB000);
      #1;
      tests_run++;
      if (mem_addr_o !== 32'hA004) begin tests_failed++; $display("FAIL t3_locked_addr: got %h expected 0000a004", mem_addr_o); end
      @(negedge clk);
      mem_gnt_i = 1'b1;
      #1;
      tests_run++;
      if (gnt_o !== 2'b01) begin tests_failed++; $display("FAIL t3_locked_gnt: got %b expected 01", gnt_o); end
      @(negedge clk);
      set_port(0, 1'b0, 32'h0);
      #1;
      tests_run++;
      if (gnt_o !== 2'b10 || mem_addr_o !== 32'hB000) begin tests_failed++; $display("FAIL t3_next: got gnt %b addr %h expected 10 b000", gnt_o, mem_addr_o); end
      @(negedge clk);
      idle();
      mem_rvalid_i = 1'b1;
      #1;
      tests_run++;
      if (rvalid_o !== 2'b01) begin tests_failed++; $display("FAIL t3_rsp0: got %b expected 01", rvalid_o); end
      @(negedge clk);
      #1;
      tests_run++;
      if (rvalid_o !== 2'b10) begin tests_failed++; $display("FAIL t3_rsp1: got %b expected 10", rvalid_o); end
      @(negedge clk);
      idle();
   endtask

   task automatic test_full();
      apply_reset();
      set_port(0, 1'b1, 32'h10);
      mem_gnt_i = 1'b1;
      @(negedge clk);
      set_port(0, 1'b0, 32'h0);
      set_port(1, 1'b1, 32'h20);
      @(negedge clk);
      set_port(1, 1'b0, 32'h0);
      set_port(0, 1'b1, 32'h30);
      #1;
      tests_run++;
      if (mem_req_o !== 1'b0 || gnt_o !== 2'b00) begin tests_failed++; $display("FAIL t4_full_req: got req %0b gnt %b expected 0 00", mem_req_o, gnt_o); end
      @(negedge clk);
      mem_rvalid_i = 1'b1;
      #1;
      tests_run++;
      if (mem_req_o !== 1'b0) begin tests_failed++; $display("FAIL t4_no_bypass: got %0b expected 0", mem_req_o); end
      tests_run++;
      if (rvalid_o !== 2'b01) begin tests_failed++; $display("FAIL t4_rsp: got %b expected 01", rvalid_o); end
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      #1;
      tests_run++;
      if (mem_req_o !== 1'b1 || gnt_o !== 2'b01) begin tests_failed++; $display("FAIL t4_resume: got req %0b gnt %b expected 1 01", mem_req_o, gnt_o); end
      @(negedge clk);
      idle();
      mem_rvalid_i = 1'b1;
      #1;
      tests_run++;
      if (rvalid_o !== 2'b10) begin tests_failed++; $display("FAIL t4_drain1: got %b expected 10", rvalid_o); end
      @(negedge clk);
      #1;
      tests_run++;
      if (rvalid_o !== 2'b01) begin tests_failed++; $display("FAIL t4_drain0: got %b expected 01", rvalid_o); end
      @(negedge clk);
      idle();
   endtask

   task automatic test_order_err();
      apply_reset();
      set_port(1, 1'b1, 32'h44);
      mem_gnt_i = 1'b1;
      #1;
      tests_run++;
      if (gnt_o !== 2'b10) begin tests_failed++; $display("FAIL t5_gnt1: got %b expected 10", gnt_o); end
      @(negedge clk);
      set_port(1, 1'b0, 32'h0);
      set_port(0, 1'b1, 32'h40);
      #1;
      tests_run++;
      if (gnt_o !== 2'b01) begin tests_failed++; $display("FAIL t5_gnt0: got %b expected 01", gnt_o); end
      @(negedge clk);
      idle();
      mem_rvalid_i = 1'b1;
      mem_err_i    = 1'b1;
      #1;
      tests_run++;
      if (rvalid_o !== 2'b10 || err_o !== 1'b1) begin tests_failed++; $display("FAIL t5_rsp_err: got rvalid %b err %0b expected 10 1", rvalid_o, err_o); end
      @(negedge clk);
      mem_err_i = 1'b0;
      #1;
      tests_run++;
      if (rvalid_o !== 2'b01 || err_o !== 1'b0) begin tests_failed++; $display("FAIL t5_rsp_ok: got rvalid %b err %0b expected 01 0", rvalid_o, err_o); end
      @(negedge clk);
      idle();
   endtask

   task automatic test_spurious();
      apply_reset();
      mem_rvalid_i = 1'b1;
      #1;
      tests_run++;
      if (rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL t6_rvalid: got %b expected 00", rvalid_o); end
      @(negedge clk);
      idle();
      repeat (3) @(negedge clk);
      #1;
      tests_run++;
      if (proto_err_o !== 1'b1) begin tests_failed++; $display("FAIL t6_sticky: got %0b expected 1", proto_err_o); end
      @(negedge clk);
      rstn = 1'b0;
      #1;
      tests_run++;
      if (proto_err_o !== 1'b0) begin tests_failed++; $display("FAIL t6_cleared: got %0b expected 0", proto_err_o); end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   // one randomized cycle checked against the reference model
   task automatic rand_cycle(input bit allow_new);
      logic [NP-1:0] exp_gnt, exp_rv;
      logic          exp_req;
      bit            full;
      int            sel, head;
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
         if (allow_new && !pend[p] && $urandom_range(0, 1) == 1) begin
            pend[p]    = 1'b1;
            p_addr[p]  = $urandom;
            p_we[p]    = 1'($urandom_range(0, 1));
            p_be[p]    = BW'($urandom);
            p_wdata[p] = $urandom;
         end
         req_i[p]            = pend[p];
         we_i[p]             = p_we[p];
         be_i[p*BW +: BW]    = p_be[p];
         addr_i[p*AW +: AW]  = p_addr[p];
         wdata_i[p*DW +: DW] = p_wdata[p];
      end
      mem_gnt_i    = ($urandom_range(0, 2) != 0);
      mem_rvalid_i = (exp_q.size() > 0) && ($urandom_range(0, 2) == 0);
      mem_rdata_i  = $urandom;
      mem_err_i    = 1'($urandom_range(0, 1));

      full = (exp_q.size() == MO);
      sel  = rr;
      if (locked >= 0) sel = locked;
      else begin
         for (int k = NP - 1; k >= 0; k--)
            if (pend[(rr + k) % NP]) sel = (rr + k) % NP;
      end
      exp_req = !full && (locked >= 0 || pend != '0);
      exp_gnt = (exp_req && mem_gnt_i) ? (NP'(1) << sel) : '0;
      head    = (exp_q.size() > 0) ? int'(exp_q[0]) : 0;
      exp_rv  = mem_rvalid_i ? (NP'(1) << head) : '0;
      #1;
      tests_run++;
      if (mem_req_o !== exp_req) begin tests_failed++; $display("FAIL rand_req: got %0b expected %0b", mem_req_o, exp_req); end
      tests_run++;
      if (gnt_o !== exp_gnt) begin tests_failed++; $display("FAIL rand_gnt: got %b expected %b", gnt_o, exp_gnt); end
      tests_run++;
      if (rvalid_o !== exp_rv) begin tests_failed++; $display("FAIL rand_rvalid: got %b expected %b", rvalid_o, exp_rv); end
      if (exp_req) begin
         tests_run++;
         if (mem_addr_o !== p_addr[sel] || mem_we_o !== p_we[sel] || mem_be_o !== p_be[sel] || mem_wdata_o !== p_wdata[sel]) begin
            tests_failed++;
            $display("FAIL rand_payload: got addr %h we %0b be %h wdata %h expected %h %0b %h %h",
                     mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, p_addr[sel], p_we[sel], p_be[sel], p_wdata[sel]);
         end
      end
      if (mem_rvalid_i) begin
         tests_run++;
         if (rdata_o !== mem_rdata_i || err_o !== mem_err_i) begin tests_failed++; $display("FAIL rand_rdata: got %h/%0b expected %h/%0b", rdata_o, err_o, mem_rdata_i, mem_err_i); end
         void'(exp_q.pop_front());
      end
      if (exp_req && mem_gnt_i) begin
         exp_q.push_back(8'(sel));
         rr        = (sel + 1) % NP;
         locked    = -1;
         pend[sel] = 1'b0;
      end else if (exp_req) begin
         locked = sel;
      end
   endtask

   task automatic test_random();
      int guard;
      apply_reset();
      pend   = '0;
      rr     = 0;
      locked = -1;
      exp_q.delete();
      for (int p = 0; p < NP; p++) begin
         p_addr[p] = '0; p_we[p] = 1'b0; p_be[p] = '0; p_wdata[p] = '0;
      end
      repeat (500) rand_cycle(1'b1);
      guard = 0;
      while ((pend != '0 || exp_q.size() > 0) && guard < 300) begin
         rand_cycle(1'b0);
         guard++;
      end
      tests_run++;
      if (pend != '0 || exp_q.size() > 0) begin tests_failed++; $display("FAIL rand_drain: %0d outstanding expected 0", exp_q.size()); end
      tests_run++;
      if (proto_err_o !== 1'b0) begin tests_failed++; $display("FAIL rand_proto_err: got %0b expected 0", proto_err_o); end
      @(negedge clk);
      idle();
   endtask

   initial begin
      idle();
      rstn = 1'b0;
      test_reset();
      test_single_read();
      test_contention();
      test_lock();
      test_full();
      test_order_err();
      test_random();
      test_spurious();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
